// File: rtl/alu_issue_unit.sv
// Issue stage for the 8-bit ALU. It accepts one register-format instruction,
// reads two operands from a local register file, captures the ALU result and writes it back.
module alu_issue_unit #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_data_out,
  input  logic [DATA_W-1:0] alu_flag_out,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] flags,
  output logic              done,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic              wb_en_q;
  logic              accept;

  assign accept = instr_valid && instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = !rst;
        busy        = 1'b0;
        if (instr_valid && !rst) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The instruction is consumed at accept, so upstream may change instr freely afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wb_en_q <= 1'b0;
    end else if (accept) begin
      op_q    <= instr[15:13];
      rd_q    <= instr[12:10];
      rs1_q   <= instr[9:7];
      rs2_q   <= instr[6:4];
      wb_en_q <= instr[3];
    end
  end

  // The ALU inputs are registered so they hold steady through the EXEC and WB cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
    end else if (state == READ) begin
      alu_in1    <= rf[rs1_q];
      alu_in2    <= rf[rs2_q];
      alu_opcode <= op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (state == EXEC) begin
      result <= alu_data_out;
      flags  <= alu_flag_out;
    end
  end

  // NOTE: the register file takes the async reset because every entry must read
  // zero afterwards; a plain RAM macro cannot be used here.
  // External preload writes happen only in IDLE and writeback only in WB, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (state == IDLE && ext_we) begin
      rf[ext_addr] <= ext_data;
    end else if (state == WB && wb_en_q) begin
      rf[rd_q] <= result;
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit. It uses an adder stub as the ALU and an
// array-based register-file model; directed cases run first, then randomized instructions.
module tb_alu_issue_unit;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic        ext_we;
  logic [2:0]  ext_addr;
  logic [7:0]  ext_data;
  logic [7:0]  alu_in1, alu_in2;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_data_out, alu_flag_out;
  logic [7:0]  result, flags;
  logic        done, busy;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad   = 0;
  int model_rf [8];

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_data_out(alu_data_out), .alu_flag_out(alu_flag_out),
    .result(result), .flags(flags), .done(done), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Adder stub standing in for the ALU.
  logic [8:0] stub_sum;
  assign stub_sum     = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_data_out = stub_sum[7:0];
  assign alu_flag_out = {7'b0, stub_sum[8]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check(tag, dbg_data, model_rf[i]);
    end
  endtask

  task automatic ext_write(input logic [2:0] addr, input logic [7:0] data);
    ext_we   = 1'b1;
    ext_addr = addr;
    ext_data = data;
    tick();
    ext_we = 1'b0;
    model_rf[addr] = data;
  endtask

  // Runs one instruction from an IDLE cycle. The instruction can carry an external write
  // in its accept cycle, and a second external write can be attempted while the unit is busy.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic wb,
                           input logic acc_we, input logic [2:0] acc_addr, input logic [7:0] acc_data,
                           input logic busy_we, input logic [2:0] busy_addr, input logic [7:0] busy_data);
    int a, b, s;
    check("ready_idle", instr_ready, 1);
    instr       = {op, rd, rs1, rs2, wb, 3'b000};
    instr_valid = 1'b1;
    ext_we      = acc_we;
    ext_addr    = acc_addr;
    ext_data    = acc_data;
    if (acc_we) model_rf[acc_addr] = acc_data;
    a = model_rf[rs1];
    b = model_rf[rs2];
    s = a + b;
    tick();                               // accept edge -> READ
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    ext_we      = busy_we;
    ext_addr    = busy_addr;
    ext_data    = busy_data;
    check("read_busy", busy, 1);
    check("read_ready", instr_ready, 0);
    check("read_done", done, 0);
    tick();                               // -> EXEC
    check("exec_in1", alu_in1, a);
    check("exec_in2", alu_in2, b);
    check("exec_opcode", alu_opcode, op);
    check("exec_done", done, 0);
    tick();                               // -> WB
    ext_we = 1'b0;
    check("wb_done", done, 1);
    check("wb_result", result, s % 256);
    check("wb_flags", flags, (s > 255) ? 1 : 0);
    tick();                               // -> IDLE
    if (wb) model_rf[rd] = s % 256;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    dbg_addr = rd;
    #1;
    check("rf_rd", dbg_data, model_rf[rd]);
    dbg_addr = busy_addr;
    #1;
    check("rf_busy_drop", dbg_data, model_rf[busy_addr]);
    check("hold_result", result, s % 256);
  endtask

  initial begin
    int low, cyc;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = 0;

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in1", alu_in1, 0);
    check("rst_in2", alu_in2, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_rf_all("rst_rf");

    // Preload and add.
    ext_write(3'd1, 8'd4);
    ext_write(3'd2, 8'd4);
    run_instr(3'd4, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);

    // Carry with writeback disabled.
    ext_write(3'd1, 8'hF0);
    ext_write(3'd2, 8'h20);
    run_instr(3'd0, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    dbg_addr = 3'd5;
    #1;
    check("nowb_r5", dbg_data, 0);

    // Back-to-back dependency with instr_valid held while the unit is busy.
    ext_write(3'd1, 8'd4);
    ext_write(3'd2, 8'd4);
    instr_valid = 1'b1;
    instr = {3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 3'b000};
    tick();                               // A accepted
    instr = {3'd0, 3'd4, 3'd3, 3'd3, 1'b1, 3'b000};
    low = 0; cyc = 0;
    while (!instr_ready && cyc < 10) begin
      low++;
      tick();
      cyc++;
    end
    check("b2b_ready_low", low, 3);
    tick();                               // B accepted, four edges after A
    instr_valid = 1'b0;
    check("b2b_b_accepted", busy, 1);
    repeat (3) tick();
    model_rf[3] = 8;
    model_rf[4] = 16;
    dbg_addr = 3'd3;
    #1;
    check("b2b_r3", dbg_data, 8);
    dbg_addr = 3'd4;
    #1;
    check("b2b_r4", dbg_data, 8'h10);
    check("b2b_ready_after", instr_ready, 1);

    // An external write while busy is dropped. An external write in the accept cycle is seen by READ.
    run_instr(3'd2, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 8'h55);
    run_instr(3'd1, 3'd0, 3'd6, 3'd2, 1'b1, 1'b1, 3'd6, 8'd7, 1'b0, 3'd6, 8'd0);

    // Reset asserted during EXEC aborts the instruction.
    instr_valid = 1'b1;
    instr = {3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 3'b000};
    tick();
    instr_valid = 1'b0;
    tick();                               // EXEC
    rst = 1'b1;
    #2;
    for (int i = 0; i < 8; i++) model_rf[i] = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check_rf_all("mid_rst_rf");
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_ready", instr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", done, 0);
    end
    dbg_addr = 3'd3;
    #1;
    check("mid_rst_r3", dbg_data, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) ext_write(3'($urandom_range(0, 7)), 8'($urandom));
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    end
    check_rf_all("final_rf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
